// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle wide-operand adder sequencer.
// Adds two N*WORDS-bit operands one N-bit word per cycle (LSW first) through a
// single N-bit ripple-carry adder, with a registered carry linking the words.
// Optional feature macro: WIDE_ADD_SUB_EN (adds the sub port for A - B).

// Plain N-bit ripple-carry adder: the only combinational arithmetic path.
module n_rca #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = c[N];
endmodule

module wide_add_seq #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef WIDE_ADD_SUB_EN
    input  logic                 sub,
`endif
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 c_out,
    output logic                 ovf
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               carry_reg, carry_next;
    logic [W-1:0]       a_reg, a_next;
    logic [W-1:0]       b_reg, b_next;
    logic [W-1:0]       sum_reg, sum_next;
    logic               c_out_reg, c_out_next;
    logic               ovf_reg, ovf_next;
`ifdef WIDE_ADD_SUB_EN
    logic               sub_reg, sub_next;
`endif

    // Operand registers viewed as word arrays so the current word is a plain mux.
    logic [N-1:0] a_words [WORDS];
    logic [N-1:0] b_words [WORDS];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign a_words[gi] = a_reg[gi*N +: N];
            assign b_words[gi] = b_reg[gi*N +: N];
        end
    endgenerate

    logic [N-1:0] x_word;
    logic [N-1:0] y_word;
    logic [N-1:0] rca_s;
    logic         rca_co;

    assign x_word = a_words[idx_reg];
`ifdef WIDE_ADD_SUB_EN
    assign y_word = sub_reg ? ~b_words[idx_reg] : b_words[idx_reg];
`else
    assign y_word = b_words[idx_reg];
`endif

    n_rca #(.N(N)) u_n_rca (
        .x  (x_word),
        .y  (y_word),
        .ci (carry_reg),
        .s  (rca_s),
        .co (rca_co)
    );

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            c_out_reg <= c_out_next;
            ovf_reg   <= ovf_next;
`ifdef WIDE_ADD_SUB_EN
            sub_reg   <= sub_next;
`endif
        end
    end

    // Next-state logic: accept from IDLE/FIN, one word per RUN cycle, FIN pulses once.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        c_out_next = c_out_reg;
        ovf_next   = ovf_reg;
`ifdef WIDE_ADD_SUB_EN
        sub_next   = sub_reg;
`endif
        case (state_reg)
            IDLE, FIN: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    sum_next   = '0;
                    idx_next   = '0;
                    state_next = RUN;
`ifdef WIDE_ADD_SUB_EN
                    sub_next   = sub;
                    carry_next = sub ? 1'b1 : c_in;
`else
                    carry_next = c_in;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_reg == IDX_W'(w)) begin
                        sum_next[w*N +: N] = rca_s;
                    end
                end
                carry_next = rca_co;
                idx_next   = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = FIN;
                    c_out_next = rca_co;
                    // Carry into the MSB xor carry out of it.
                    ovf_next   = (x_word[N-1] ^ y_word[N-1] ^ rca_s[N-1]) ^ rca_co;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == FIN);
    assign sum   = sum_reg;
    assign c_out = c_out_reg;
    assign ovf   = ovf_reg;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq (N=32, WORDS=4).
// Optional feature macro: WIDE_ADD_SUB_EN enables the subtract scenarios.
module tb_wide_add_seq;
    localparam int N     = 32;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int checks;
    int errors;

    wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef WIDE_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait (bounded) for DONE; reports latency and busy cycles.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic sb, output int lat, output int busy_cyc);
        a = av; b = bv; c_in = ci; sub = sb; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
        $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h c_out=%0d ovf=%0d lat=%0d",
                 av, bv, ci, sb, sum, c_out, ovf, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, c_out, ovf} !== 4'b0000 || sum !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b c_out=%b ovf=%b sum=%h, required all 0",
                     busy, done, c_out, ovf, sum);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        int lat, bc;
        do_op(128'h1, 128'h2, 1'b0, 1'b0, lat, bc);
        checks++;
        if (lat !== WORDS || bc !== WORDS) begin
            errors++;
            $display("FAIL basic_timing: lat=%0d busy_cycles=%0d, required %0d/%0d", lat, bc, WORDS, WORDS);
        end
        checks++;
        if (sum !== 128'h3 || c_out !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: sum=%h c_out=%b ovf=%b, required 3/0/0", sum, c_out, ovf);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_in_fin: busy=%b, required 0", busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
        end
        tick(); tick();
        checks++;
        if (sum !== 128'h3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_persist: sum=%h busy=%b, required 3/0", sum, busy);
        end
    endtask

    task automatic test_carry_ripple();
        int lat, bc;
        logic [W-1:0] ones;
        ones = '1;
        do_op(ones, '0, 1'b1, 1'b0, lat, bc);
        checks++;
        if (lat !== WORDS || sum !== '0 || c_out !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_ripple: lat=%0d sum=%h c_out=%b ovf=%b, required 4/0/1/0", lat, sum, c_out, ovf);
        end
        tick();
        // Carry crossing only the first word boundary.
        do_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0, lat, bc);
        checks++;
        if (sum !== 128'h0000_0000_0000_0000_0000_0001_0000_0000 || c_out !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL word_carry: sum=%h c_out=%b ovf=%b, required 1_00000000/0/0", sum, c_out, ovf);
        end
        tick();
    endtask

    task automatic test_overflow();
        int lat, bc;
        logic [W-1:0] max_pos;
        logic [W-1:0] min_neg;
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};
        do_op(max_pos, 128'h1, 1'b0, 1'b0, lat, bc);
        checks++;
        if (sum !== min_neg || ovf !== 1'b1 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL signed_overflow: sum=%h ovf=%b c_out=%b, required %h/1/0", sum, ovf, c_out, min_neg);
        end
        tick();
        // -1 + -1 = -2: carry out but no signed overflow.
        do_op('1, '1, 1'b0, 1'b0, lat, bc);
        checks++;
        if (sum !== {{(W-1){1'b1}}, 1'b0} || ovf !== 1'b0 || c_out !== 1'b1) begin
            errors++;
            $display("FAIL neg_add: sum=%h ovf=%b c_out=%b, required ff..fe/0/1", sum, ovf, c_out);
        end
        tick();
    endtask

    task automatic test_start_in_run();
        int done_cnt;
        int first_done;
        a = 128'h100; b = 128'h23; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        tick();                         // E0
        start = 1'b0;
        tick();                         // E1
        tick();                         // E2
        a = '1; b = '1; c_in = 1'b1; start = 1'b1;
        tick();                         // E3: START ignored
        start = 1'b0;
        done_cnt = 0;
        first_done = -1;
        for (int i = 3; i < 12; i++) begin
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
            tick();
        end
        $display("op start_in_run: sum=%h done_pulses=%0d first_done=E%0d", sum, done_cnt, first_done);
        checks++;
        if (done_cnt !== 1 || first_done !== WORDS) begin
            errors++;
            $display("FAIL start_in_run_done: pulses=%0d at E%0d, required 1 at E%0d", done_cnt, first_done, WORDS);
        end
        checks++;
        if (sum !== 128'h123 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run_result: sum=%h c_out=%b, required 123/0", sum, c_out);
        end
    endtask

    task automatic test_back_to_back_reset();
        int done_at [2];
        int nd;
        int bad;
        a = 128'h1; b = 128'h2; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        tick();                         // E0
        a = 128'h10; b = 128'h20;       // captured only at the FIN accept
        nd = 0;
        for (int i = 0; i < 12 && nd < 2; i++) begin
            if (done) begin
                done_at[nd] = i;
                if (nd == 0) begin
                    checks++;
                    if (sum !== 128'h3) begin
                        errors++;
                        $display("FAIL b2b_first: sum=%h, required 3", sum);
                    end
                end else begin
                    checks++;
                    if (sum !== 128'h30) begin
                        errors++;
                        $display("FAIL b2b_second: sum=%h, required 30", sum);
                    end
                end
                nd++;
            end
            if (nd < 2) tick();
        end
        $display("op back_to_back: done pulses=%0d at cycles %0d,%0d", nd, done_at[0], done_at[1]);
        checks++;
        if (nd !== 2 || done_at[0] !== WORDS || done_at[1] - done_at[0] !== WORDS + 1) begin
            errors++;
            $display("FAIL b2b_period: pulses=%0d first=%0d second=%0d, required 2 at %0d and %0d",
                     nd, done_at[0], done_at[1], WORDS, 2 * WORDS + 1);
        end
        // START still high: third accept happens at the next edge; reset mid-RUN.
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, c_out, ovf} !== 4'b0000 || sum !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b c_out=%b ovf=%b sum=%h, required all 0",
                     busy, done, c_out, ovf, sum);
        end
        tick();
        #2 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        $display("op reset_mid_run: post-reset bad cycles=%0d", bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d cycles with done/busy set, required 0", bad);
        end
    endtask

`ifdef WIDE_ADD_SUB_EN
    task automatic test_sub();
        int lat, bc;
        do_op(128'h5, 128'h7, 1'b0, 1'b1, lat, bc);
        checks++;
        if (sum !== {{(W-1){1'b1}}, 1'b0} || c_out !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: sum=%h c_out=%b ovf=%b, required ff..fe/0/0", sum, c_out, ovf);
        end
        tick();
        do_op(128'h7, 128'h5, 1'b0, 1'b1, lat, bc);
        checks++;
        if (sum !== 128'h2 || c_out !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_no_borrow: sum=%h c_out=%b ovf=%b, required 2/1/0", sum, c_out, ovf);
        end
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_overflow();
        test_start_in_run();
        test_back_to_back_reset();
`ifdef WIDE_ADD_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
